// File: rtl/ov5642_capture.sv
// OV5642 DVP capture: keeps the luma byte of each YUV422 pair and streams it to a frame buffer write port.
// Optional OV5642_FRAME_DONE_EN adds a one-cycle frame_done pulse on vsync rise after a frame with writes.
module ov5642_capture #(
  parameter int H_PIXELS     = 320,
  parameter int FRAME_PIXELS = 76800,
  parameter int Y_PHASE      = 1
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic [7:0]  cam_data,
  input  logic        href,
  input  logic        vsync,
  output logic [16:0] address,
  output logic [7:0]  pix_data,
  output logic        write_enable
`ifdef OV5642_FRAME_DONE_EN
  ,
  output logic        frame_done
`endif
);

  localparam logic        Y_SEL     = (Y_PHASE != 0);
  localparam logic [17:0] FRAME_MAX = 18'(FRAME_PIXELS);

  if (FRAME_PIXELS > 131072 || FRAME_PIXELS < 1 || H_PIXELS < 1) begin : g_param_check
    $error("ov5642_capture: FRAME_PIXELS must be in 1..2^17");
  end

  // One extra counter bit so the counter can sit at FRAME_PIXELS == 2^17.
  logic [17:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [16:0] address_q, address_d;
  logic [7:0]  pix_data_q, pix_data_d;
  logic        write_enable_q, write_enable_d;

  always_comb begin
    cnt_d          = cnt_q;
    phase_d        = phase_q;
    address_d      = address_q;
    pix_data_d     = pix_data_q;
    write_enable_d = 1'b0;
    if (vsync) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (href) begin
      phase_d = ~phase_q;
      if (phase_q == Y_SEL && cnt_q < FRAME_MAX) begin
        pix_data_d     = cam_data;
        address_d      = cnt_q[16:0];
        write_enable_d = 1'b1;
        cnt_d          = cnt_q + 18'd1;
      end
    end else begin
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      cnt_q          <= '0;
      phase_q        <= 1'b0;
      address_q      <= '0;
      pix_data_q     <= '0;
      write_enable_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      phase_q        <= phase_d;
      address_q      <= address_d;
      pix_data_q     <= pix_data_d;
      write_enable_q <= write_enable_d;
    end
  end

  assign address      = address_q;
  assign pix_data     = pix_data_q;
  assign write_enable = write_enable_q;

`ifdef OV5642_FRAME_DONE_EN
  logic vsync_prev_q, vsync_prev_d;
  logic written_q, written_d;
  logic frame_done_q, frame_done_d;

  always_comb begin
    vsync_prev_d = vsync;
    written_d    = written_q | write_enable_d;
    frame_done_d = 1'b0;
    if (vsync && !vsync_prev_q) begin
      frame_done_d = written_q;
      written_d    = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      vsync_prev_q <= 1'b0;
      written_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      written_q    <= written_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_ov5642_capture.sv
// Directed bench for ov5642_capture: default build, a Y_PHASE=0 build and a small-frame build share one stimulus.
module tb_ov5642_capture;
  logic        pclk = 1'b0;
  logic        reset_n;
  logic [7:0]  cam_data;
  logic        href;
  logic        vsync;

  logic [16:0] addr_a, addr_b, addr_c;
  logic [7:0]  pix_a, pix_b, pix_c;
  logic        we_a, we_b, we_c;
`ifdef OV5642_FRAME_DONE_EN
  logic        fd_a, fd_b, fd_c;
  int          fd_count = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  // a: defaults, b: Y_PHASE=0, c: FRAME_PIXELS=16 to reach frame-full quickly
  ov5642_capture dut_a (
    .pclk(pclk), .reset_n(reset_n), .cam_data(cam_data), .href(href), .vsync(vsync),
    .address(addr_a), .pix_data(pix_a), .write_enable(we_a)
`ifdef OV5642_FRAME_DONE_EN
    , .frame_done(fd_a)
`endif
  );

  ov5642_capture #(.Y_PHASE(0)) dut_b (
    .pclk(pclk), .reset_n(reset_n), .cam_data(cam_data), .href(href), .vsync(vsync),
    .address(addr_b), .pix_data(pix_b), .write_enable(we_b)
`ifdef OV5642_FRAME_DONE_EN
    , .frame_done(fd_b)
`endif
  );

  ov5642_capture #(.FRAME_PIXELS(16)) dut_c (
    .pclk(pclk), .reset_n(reset_n), .cam_data(cam_data), .href(href), .vsync(vsync),
    .address(addr_c), .pix_data(pix_c), .write_enable(we_c)
`ifdef OV5642_FRAME_DONE_EN
    , .frame_done(fd_c)
`endif
  );

`ifdef OV5642_FRAME_DONE_EN
  always @(posedge pclk) begin
    #1;
    if (reset_n && fd_a) fd_count++;
  end
`endif

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic cycle(input logic h, input logic v, input logic [7:0] d);
    @(negedge pclk);
    href     = h;
    vsync    = v;
    cam_data = d;
    @(posedge pclk);
    #1;
  endtask

  initial begin
    int d;
    reset_n  = 1'b0;
    href     = 1'b1;
    vsync    = 1'b0;
    cam_data = 8'h00;

    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, (i == 0) ? 8'hAA : 8'h55);
      check_eq("reset_we",   int'(we_a),   0);
      check_eq("reset_addr", int'(addr_a), 0);
      check_eq("reset_pix",  int'(pix_a),  0);
      check_eq("reset_we_b", int'(we_b),   0);
    end
    $display("reset: outputs held at zero for 2 cycles");

    // Basic line: 255,10,255,20,255,30 repeating, 24 bytes
    reset_n = 1'b1;
    cycle(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 24; i++) begin
      d = (i % 2 == 0) ? 255 : 10 * (((i / 2) % 3) + 1);
      cycle(1'b1, 1'b0, 8'(d));
      check_eq("basic_we", int'(we_a), i % 2);
      if (i % 2 == 1) begin
        check_eq("basic_pix",  int'(pix_a),  d);
        check_eq("basic_addr", int'(addr_a), i / 2);
      end
      check_eq("y0_we", int'(we_b), (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) begin
        check_eq("y0_pix",  int'(pix_b),  255);
        check_eq("y0_addr", int'(addr_b), i / 2);
      end
    end
    cycle(1'b0, 1'b0, 8'h00);
    check_eq("basic_we_end", int'(we_a), 0);
    check_eq("basic_hold_addr", int'(addr_a), 11);
    $display("basic line: 24 bytes, 12 writes expected");

    // Multi-line: odd-length line of 641 bytes then 640 bytes, addresses contiguous
    cycle(1'b0, 1'b1, 8'h00);
    for (int l = 0; l < 2; l++) begin
      int len;
      len = (l == 0) ? 641 : 640;
      for (int j = 0; j < len; j++) begin
        cycle(1'b1, 1'b0, 8'(j));
        check_eq("ml_we", int'(we_a), (j % 2 == 1) ? 1 : 0);
        if (j % 2 == 1) begin
          check_eq("ml_addr", int'(addr_a), l * 320 + j / 2);
          check_eq("ml_pix",  int'(pix_a),  j % 256);
        end
      end
      for (int g = 0; g < 3; g++) begin
        cycle(1'b0, 1'b0, 8'hEE);
        check_eq("ml_gap_we", int'(we_a), 0);
      end
      $display("multi-line: line %0d of %0d bytes done", l, len);
    end
    check_eq("ml_last_addr", int'(addr_a), 639);

    // vsync restart: 5 writes, then 2 cycles of vsync with href high, then a new line
    cycle(1'b0, 1'b1, 8'h00);
    for (int j = 0; j < 10; j++) cycle(1'b1, 1'b0, 8'(100 + j));
    check_eq("vr_addr5", int'(addr_a), 4);
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, 1'b1, 8'h77);
      check_eq("vr_vsync_we",   int'(we_a),   0);
      check_eq("vr_vsync_addr", int'(addr_a), 4);
      check_eq("vr_vsync_pix",  int'(pix_a),  109);
    end
    cycle(1'b0, 1'b0, 8'h00);
    for (int j = 0; j < 4; j++) begin
      cycle(1'b1, 1'b0, 8'(200 + j));
      check_eq("vr_we", int'(we_a), j % 2);
      if (j == 1) begin
        check_eq("vr_addr0", int'(addr_a), 0);
        check_eq("vr_pix0",  int'(pix_a),  201);
      end
    end
    cycle(1'b0, 1'b0, 8'h00);
    $display("vsync restart: next write at address 0 expected");

    // Frame full on the 16-pixel build: 34 bytes, last write at 15, rest dropped
    cycle(1'b0, 1'b1, 8'h00);
    for (int j = 0; j < 34; j++) begin
      cycle(1'b1, 1'b0, 8'(j + 1));
      check_eq("ff_we", int'(we_c), (j % 2 == 1 && j / 2 < 16) ? 1 : 0);
      if (j % 2 == 1) begin
        check_eq("ff_addr", int'(addr_c), (j / 2 < 16) ? j / 2 : 15);
        check_eq("ff_main_addr", int'(addr_a), j / 2);
      end
    end
    check_eq("ff_hold_pix", int'(pix_c), 32);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);
    for (int j = 0; j < 4; j++) begin
      cycle(1'b1, 1'b0, 8'(50 + j));
      check_eq("ff_next_we", int'(we_c), j % 2);
      if (j == 1) begin
        check_eq("ff_next_addr", int'(addr_c), 0);
        check_eq("ff_next_pix",  int'(pix_c),  51);
      end
    end
    cycle(1'b0, 1'b0, 8'h00);
    $display("frame full: 16-pixel frame capped at address 15, next frame restarts at 0");

`ifdef OV5642_FRAME_DONE_EN
    check_eq("frame_done_count", fd_count, 5);
    $display("frame_done: %0d pulses observed", fd_count);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
